flag_branch_unit: RTL and testbench
===================================

# flag_branch_unit

Consumer end of the ALU status interface: holds the architectural condition flags S, Z, C and V and resolves conditional branches against them. It latches the flags when the execute stage writes them and keeps a small LIFO of saved flag words for interrupt and call entry and exit. It evaluates branch requests through a valid/ready handshake and returns a registered taken/target result to the PC logic. It sits between the ALU flag outputs and the fetch stage.

## Interface
- DEPTH, 4: number of entries in the flag save stack (≥1).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flag_we  in  1  latch s_in/z_in/c_in/v_in this cycle.
- s_in, z_in, c_in, v_in  in  1 each  flag values from the ALU.
- push  in  1  save the current flag register onto the stack.
- pop  in  1  restore the flag register from the stack top.
- br_valid  in  1  branch request valid.
- br_ready  out  1  unit accepts a request this cycle.
- br_cond  in  3  condition code: 000 BE, 001 BLT, 010 BLE, 011 BNE, 100 always, 101 BC, 110 BNC, 111 never.
- br_pc  in  16  PC of the branch instruction.
- br_disp  in  8  signed displacement.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res_taken  out  1  branch taken.
- res_target  out  16  next PC.
- flush  in  1  pipeline flush.
- flags  out  4  {S,Z,C,V} register.
- stack_empty, stack_full  out  1 each  stack occupancy status.
- stack_err  out  1  one-cycle pulse on push-when-full or pop-when-empty.

## Operation
- **Reset:** flags=0000, stack count=0 (stack_empty=1, stack_full=0), res_valid=0, res_taken=0, res_target=0, stack_err=0.
- **Flag register:**
  - If flag_we=1 and pop=0, flags take the *_in values at the clock edge.
  - pop has priority over flag_we; flag_we is dropped in a pop cycle.
- **Push:** writes the pre-edge flags value, so a simultaneous flag_we still updates the register and the old value is the one saved.
- **Pop:** loads the top entry into flags and decrements the count.
- **push and pop in the same cycle:** no-op; no error.
- **Push when full / pop when empty:** ignored, with stack_err pulsed for one cycle. Flags and count are unchanged.
- **Condition evaluation** uses effective flags: the *_in values when flag_we=1 in the acceptance cycle (bypass), else the flags register. A pop in the same cycle does not bypass; the branch sees the pre-pop register.
- **Condition terms:**
  - BE = Z
  - BLT = S^V
  - BLE = Z|(S^V)
  - BNE = ~Z
  - BC = C
  - BNC = ~C
  - always = 1
  - never = 0
- **Target:**
  - Taken: br_pc + 1 + sign-extended br_disp, modulo 2^16 (wraps; no flag).
  - Not taken: br_pc + 1, modulo 2^16.
- **Handshake:**
  - br_ready = ~flush & (~res_valid | res_ready).
  - A request is accepted on br_valid & br_ready.
  - The result register holds res_taken/res_target stable while res_valid=1 and res_ready=0.
- **Flush:**
  - At the edge, res_valid is cleared and no request is accepted.
  - Flags and the stack are unaffected.

## Timing
- **Branch latency:** one cycle. A request accepted at edge N gives res_valid=1 after edge N.
- **res_valid clear:** after an edge where res_ready=1 and no new acceptance occurs.
- **Back-to-back requests:** when res_ready is held high, one result is produced per cycle.
- **Flag update:** flags visible on the output one cycle after flag_we. Branches in the same cycle see the new value via bypass.
- **stack_empty/stack_full:** registered from the count, valid the cycle after the push/pop edge.
- **Reset mid-operation:** all state returns to reset values immediately, asynchronously, and the pending result is lost.

## Test plan
- **Bypass:** flags=0000; flag_we with Z=1 in the same cycle as br_valid, BE, br_pc=0x0010, disp=0xFE → next cycle res_valid=1, taken=1, target=0x000F.
- **Overflow conditions and wrap:** S=1,V=1 latched; BLT → taken=0, target=pc+1. Then S=1,V=0 latched, br_pc=0xFFFF, disp=0x01 → taken=1, target=0x0001 (wrap).
- **Backpressure:**
  - res_ready=0 for 3 cycles → res_valid stays 1, outputs stable, br_ready=0.
  - Raise res_ready → second request accepted, result the following cycle.
- **Flush with pending result:** flush with res_valid=1 → res_valid=0 next cycle, br_ready=0 during the flush, flags unchanged.
- **Stack:**
  - DEPTH=4 pushes of 0001,0010,0100,1000 → stack_full=1; fifth push → stack_err pulse.
  - Four pops restore 1000,0100,0010,0001 in order; fifth pop → stack_err, flags stay 0001.
- **Simultaneous events and reset:**
  - push+flag_we → stack holds the old value, flags take the new one.
  - pop+flag_we → flags = popped value.
  - push+pop → no change.
  - rst_n low mid-sequence → all outputs at reset values.

Source files
------------

// File: rtl/flag_branch_unit.sv
// rtl/flag_branch_unit.sv - condition flag register, flag save stack and branch resolver
module flag_branch_unit #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flag_we,
   input  logic        s_in,
   input  logic        z_in,
   input  logic        c_in,
   input  logic        v_in,
   input  logic        push,
   input  logic        pop,
   input  logic        br_valid,
   output logic        br_ready,
   input  logic [2:0]  br_cond,
   input  logic [15:0] br_pc,
   input  logic [7:0]  br_disp,
   output logic        res_valid,
   input  logic        res_ready,
   output logic        res_taken,
   output logic [15:0] res_target,
   input  logic        flush,
   output logic [3:0]  flags,
   output logic        stack_empty,
   output logic        stack_full,
   output logic        stack_err
);

   // count needs to reach DEPTH itself; the entry index only spans DEPTH slots
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);
   localparam logic [CW-1:0] ZERO_CNT = '0;

   // branch condition codes
   localparam logic [2:0] C_BE     = 3'b000;
   localparam logic [2:0] C_BLT    = 3'b001;
   localparam logic [2:0] C_BLE    = 3'b010;
   localparam logic [2:0] C_BNE    = 3'b011;
   localparam logic [2:0] C_ALWAYS = 3'b100;
   localparam logic [2:0] C_BC     = 3'b101;
   localparam logic [2:0] C_BNC    = 3'b110;
   localparam logic [2:0] C_NEVER  = 3'b111;

   logic [3:0]    flags_q;
   logic [3:0]    stack_mem [DEPTH];
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic [CW-1:0] count_m1;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;
   logic          is_full;
   logic          is_empty;
   logic          push_only;
   logic          pop_only;
   logic          do_push;
   logic          do_pop;
   logic          err_d;
   logic          empty_q;
   logic          full_q;
   logic          err_q;

   logic          accept;
   logic [3:0]    eff_flags;
   logic          eff_s;
   logic          eff_z;
   logic          eff_c;
   logic          eff_v;
   logic          cond_true;
   logic [15:0]   pc_next;
   logic [15:0]   pc_branch;
   logic          res_valid_q;
   logic          res_taken_q;
   logic [15:0]   res_target_q;

   // stack control: push and pop together cancel out without error
   assign is_full   = (count_q == FULL_CNT);
   assign is_empty  = (count_q == ZERO_CNT);
   assign push_only = push & ~pop;
   assign pop_only  = pop & ~push;
   assign do_push   = push_only & ~is_full;
   assign do_pop    = pop_only & ~is_empty;
   assign err_d     = (push_only & is_full) | (pop_only & is_empty);
   assign count_m1  = count_q - ONE_CNT;
   assign wr_idx    = count_q[AW-1:0];
   assign rd_idx    = count_m1[AW-1:0];

   // next occupancy, used to register the empty/full status
   always_comb begin
      count_d = count_q;
      if (do_push) begin
         count_d = count_q + ONE_CNT;
      end else if (do_pop) begin
         count_d = count_m1;
      end
   end

   // stack storage holds the pre-edge flag register value
   always_ff @(posedge clk) begin
      if (do_push) begin
         stack_mem[wr_idx] <= flags_q;
      end
   end

   // flag register and stack occupancy; any pop cycle drops flag_we
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= 4'b0000;
         count_q <= ZERO_CNT;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (do_pop) begin
            flags_q <= stack_mem[rd_idx];
         end else if (flag_we && !pop) begin
            flags_q <= {s_in, z_in, c_in, v_in};
         end
         count_q <= count_d;
         empty_q <= (count_d == ZERO_CNT);
         full_q  <= (count_d == FULL_CNT);
         err_q   <= err_d;
      end
   end

   // branches see ALU flags directly when they are being written, except in a pop cycle
   assign eff_flags = (flag_we && !pop) ? {s_in, z_in, c_in, v_in} : flags_q;
   assign eff_s     = eff_flags[3];
   assign eff_z     = eff_flags[2];
   assign eff_c     = eff_flags[1];
   assign eff_v     = eff_flags[0];

   // condition resolution against the effective flags
   always_comb begin
      cond_true = 1'b0;
      case (br_cond)
         C_BE:     cond_true = eff_z;
         C_BLT:    cond_true = eff_s ^ eff_v;
         C_BLE:    cond_true = eff_z | (eff_s ^ eff_v);
         C_BNE:    cond_true = ~eff_z;
         C_ALWAYS: cond_true = 1'b1;
         C_BC:     cond_true = eff_c;
         C_BNC:    cond_true = ~eff_c;
         C_NEVER:  cond_true = 1'b0;
         default:  cond_true = 1'b0;
      endcase
   end

   // both candidate targets wrap modulo 2^16
   assign pc_next   = br_pc + 16'd1;
   assign pc_branch = pc_next + {{8{br_disp[7]}}, br_disp};

   assign br_ready = ~flush & (~res_valid_q | res_ready);
   assign accept   = br_valid & br_ready;

   // result register: held while the consumer stalls, dropped on flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid_q  <= 1'b0;
         res_taken_q  <= 1'b0;
         res_target_q <= 16'h0000;
      end else if (flush) begin
         res_valid_q <= 1'b0;
      end else if (accept) begin
         res_valid_q  <= 1'b1;
         res_taken_q  <= cond_true;
         res_target_q <= cond_true ? pc_branch : pc_next;
      end else if (res_ready) begin
         res_valid_q <= 1'b0;
      end
   end

   assign res_valid   = res_valid_q;
   assign res_taken   = res_taken_q;
   assign res_target  = res_target_q;
   assign flags       = flags_q;
   assign stack_empty = empty_q;
   assign stack_full  = full_q;
   assign stack_err   = err_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// tb/tb_flag_branch_unit.sv - directed self-checking bench for flag_branch_unit
`timescale 1ns/1ps
module tb_flag_branch_unit;

   logic        clk;
   logic        rst_n;
   logic        flag_we;
   logic        s_in, z_in, c_in, v_in;
   logic        push, pop;
   logic        br_valid;
   logic        br_ready;
   logic [2:0]  br_cond;
   logic [15:0] br_pc;
   logic [7:0]  br_disp;
   logic        res_valid;
   logic        res_ready;
   logic        res_taken;
   logic [15:0] res_target;
   logic        flush;
   logic [3:0]  flags;
   logic        stack_empty, stack_full, stack_err;

   int checks;
   int failures;

   flag_branch_unit #(.DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
      .s_in(s_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
      .push(push), .pop(pop),
      .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
      .br_pc(br_pc), .br_disp(br_disp),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_taken(res_taken), .res_target(res_target),
      .flush(flush), .flags(flags),
      .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flag_we = 0; s_in = 0; z_in = 0; c_in = 0; v_in = 0;
      push = 0; pop = 0; br_valid = 0; br_cond = 3'b000;
      br_pc = 16'h0000; br_disp = 8'h00; res_ready = 1; flush = 0;
   endtask

   task automatic set_flags(input logic [3:0] f);
      flag_we = 1; {s_in, z_in, c_in, v_in} = f;
      step();
      flag_we = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      #12;
      checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", flags); end
      checks++; if (stack_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", stack_empty); end
      checks++; if (stack_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", stack_full); end
      checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
      checks++; if (res_taken !== 1'b0) begin failures++; $display("FAIL reset_res_taken got=%b exp=0", res_taken); end
      checks++; if (res_target !== 16'h0000) begin failures++; $display("FAIL reset_res_target got=%h exp=0000", res_target); end
      checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", stack_err); end
      checks++; if (br_ready !== 1'b1) begin failures++; $display("FAIL reset_br_ready got=%b exp=1", br_ready); end
      @(posedge clk); #1;
      rst_n = 1;
      step();
   endtask

   task automatic test_bypass();
      flag_we = 1; {s_in, z_in, c_in, v_in} = 4'b0100;
      br_valid = 1; br_cond = 3'b000; br_pc = 16'h0010; br_disp = 8'hFE;
      step();
      idle_inputs();
      checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bypass_valid got=%b exp=1", res_valid); end
      checks++; if (res_taken !== 1'b1) begin failures++; $display("FAIL bypass_taken got=%b exp=1", res_taken); end
      checks++; if (res_target !== 16'h000F) begin failures++; $display("FAIL bypass_target got=%h exp=000f", res_target); end
      checks++; if (flags !== 4'b0100) begin failures++; $display("FAIL bypass_flags got=%b exp=0100", flags); end
      step();
      checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL bypass_clear got=%b exp=0", res_valid); end
   endtask

   task automatic test_overflow();
      set_flags(4'b1001);
      br_valid = 1; br_cond = 3'b001; br_pc = 16'h0020; br_disp = 8'h05;
      step();
      br_valid = 0;
      checks++; if (res_taken !== 1'b0) begin failures++; $display("FAIL blt_sv_taken got=%b exp=0", res_taken); end
      checks++; if (res_target !== 16'h0021) begin failures++; $display("FAIL blt_sv_target got=%h exp=0021", res_target); end
      set_flags(4'b1000);
      br_valid = 1; br_cond = 3'b001; br_pc = 16'hFFFF; br_disp = 8'h01;
      step();
      br_valid = 0;
      checks++; if (res_taken !== 1'b1) begin failures++; $display("FAIL blt_wrap_taken got=%b exp=1", res_taken); end
      checks++; if (res_target !== 16'h0001) begin failures++; $display("FAIL blt_wrap_target got=%h exp=0001", res_target); end
      step();
   endtask

   // flags are 1000 here: S=1 Z=0 C=0 V=0
   task automatic test_back_to_back();
      logic [7:0]  exp_taken;
      logic [15:0] pc;
      logic [15:0] exp_tgt;
      exp_taken = 8'b0101_1110;
      res_ready = 1;
      for (int i = 0; i < 8; i++) begin
         pc = 16'h0100 + 16'(i);
         br_valid = 1; br_cond = 3'(i); br_pc = pc; br_disp = 8'h10;
         checks++; if (br_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, br_ready); end
         step();
         exp_tgt = exp_taken[i] ? (pc + 16'h0011) : (pc + 16'h0001);
         checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, res_valid); end
         checks++; if (res_taken !== exp_taken[i]) begin failures++; $display("FAIL b2b_taken[%0d] got=%b exp=%b", i, res_taken, exp_taken[i]); end
         checks++; if (res_target !== exp_tgt) begin failures++; $display("FAIL b2b_target[%0d] got=%h exp=%h", i, res_target, exp_tgt); end
      end
      br_valid = 0;
      step();
   endtask

   task automatic test_backpressure();
      res_ready = 0;
      br_valid = 1; br_cond = 3'b100; br_pc = 16'h0200; br_disp = 8'h80;
      step();
      br_cond = 3'b111; br_pc = 16'h0300; br_disp = 8'h22;
      for (int i = 0; i < 3; i++) begin
         checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, res_valid); end
         checks++; if (res_target !== 16'h0181) begin failures++; $display("FAIL bp_target[%0d] got=%h exp=0181", i, res_target); end
         checks++; if (res_taken !== 1'b1) begin failures++; $display("FAIL bp_taken[%0d] got=%b exp=1", i, res_taken); end
         checks++; if (br_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, br_ready); end
         step();
      end
      res_ready = 1;
      #1;
      checks++; if (br_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_release got=%b exp=1", br_ready); end
      step();
      br_valid = 0;
      checks++; if (res_taken !== 1'b0) begin failures++; $display("FAIL bp_second_taken got=%b exp=0", res_taken); end
      checks++; if (res_target !== 16'h0301) begin failures++; $display("FAIL bp_second_target got=%h exp=0301", res_target); end
      step();
      checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", res_valid); end
   endtask

   task automatic test_flush();
      res_ready = 0;
      br_valid = 1; br_cond = 3'b100; br_pc = 16'h0400; br_disp = 8'h00;
      step();
      flush = 1;
      #1;
      checks++; if (br_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", br_ready); end
      step();
      flush = 0; br_valid = 0; res_ready = 1;
      checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", res_valid); end
      checks++; if (flags !== 4'b1000) begin failures++; $display("FAIL flush_flags got=%b exp=1000", flags); end
      step();
   endtask

   task automatic test_stack();
      logic [3:0] vals [4];
      vals[0] = 4'b0001; vals[1] = 4'b0010; vals[2] = 4'b0100; vals[3] = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         set_flags(vals[i]);
         push = 1; step(); push = 0;
      end
      checks++; if (stack_full !== 1'b1) begin failures++; $display("FAIL stk_full got=%b exp=1", stack_full); end
      checks++; if (stack_empty !== 1'b0) begin failures++; $display("FAIL stk_not_empty got=%b exp=0", stack_empty); end
      checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL stk_no_err got=%b exp=0", stack_err); end
      set_flags(4'b1111);
      push = 1; step(); push = 0;
      checks++; if (stack_err !== 1'b1) begin failures++; $display("FAIL stk_push_full_err got=%b exp=1", stack_err); end
      step();
      checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL stk_err_pulse got=%b exp=0", stack_err); end
      for (int i = 3; i >= 0; i--) begin
         pop = 1; step(); pop = 0;
         checks++; if (flags !== vals[i]) begin failures++; $display("FAIL stk_pop[%0d] got=%b exp=%b", i, flags, vals[i]); end
      end
      checks++; if (stack_empty !== 1'b1) begin failures++; $display("FAIL stk_empty got=%b exp=1", stack_empty); end
      pop = 1; step(); pop = 0;
      checks++; if (stack_err !== 1'b1) begin failures++; $display("FAIL stk_pop_empty_err got=%b exp=1", stack_err); end
      checks++; if (flags !== 4'b0001) begin failures++; $display("FAIL stk_pop_empty_flags got=%b exp=0001", flags); end
      step();
   endtask

   task automatic test_simultaneous();
      // push with flag_we saves the old value (0001)
      push = 1; flag_we = 1; {s_in, z_in, c_in, v_in} = 4'b1010;
      step();
      push = 0; flag_we = 0;
      checks++; if (flags !== 4'b1010) begin failures++; $display("FAIL sim_push_we_flags got=%b exp=1010", flags); end
      checks++; if (stack_empty !== 1'b0) begin failures++; $display("FAIL sim_push_we_count got=%b exp=0", stack_empty); end
      // pop with flag_we: popped value wins, branch sees pre-pop register 1010 (Z=0)
      pop = 1; flag_we = 1; {s_in, z_in, c_in, v_in} = 4'b0100;
      br_valid = 1; br_cond = 3'b000; br_pc = 16'h0500; br_disp = 8'h04;
      step();
      pop = 0; flag_we = 0; br_valid = 0;
      checks++; if (flags !== 4'b0001) begin failures++; $display("FAIL sim_pop_we_flags got=%b exp=0001", flags); end
      checks++; if (res_taken !== 1'b0) begin failures++; $display("FAIL sim_pop_no_bypass got=%b exp=0", res_taken); end
      // push and pop together change nothing
      push = 1; pop = 1;
      step();
      push = 0; pop = 0;
      checks++; if (flags !== 4'b0001) begin failures++; $display("FAIL sim_pushpop_flags got=%b exp=0001", flags); end
      checks++; if (stack_empty !== 1'b1) begin failures++; $display("FAIL sim_pushpop_empty got=%b exp=1", stack_empty); end
      checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL sim_pushpop_err got=%b exp=0", stack_err); end
   endtask

   task automatic test_reset_mid();
      push = 1; step(); push = 0;
      set_flags(4'b0110);
      res_ready = 0;
      br_valid = 1; br_cond = 3'b100; br_pc = 16'h0600; br_disp = 8'h03;
      step();
      br_valid = 0;
      #2;
      rst_n = 0;
      #1;
      checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL rstmid_flags got=%b exp=0000", flags); end
      checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", res_valid); end
      checks++; if (res_target !== 16'h0000) begin failures++; $display("FAIL rstmid_target got=%h exp=0000", res_target); end
      checks++; if (res_taken !== 1'b0) begin failures++; $display("FAIL rstmid_taken got=%b exp=0", res_taken); end
      checks++; if (stack_empty !== 1'b1) begin failures++; $display("FAIL rstmid_empty got=%b exp=1", stack_empty); end
      checks++; if (stack_full !== 1'b0) begin failures++; $display("FAIL rstmid_full got=%b exp=0", stack_full); end
      idle_inputs();
      @(posedge clk); #1;
      rst_n = 1;
      step();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 0;
      idle_inputs();
      test_reset();
      test_bypass();
      test_overflow();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_stack();
      test_simultaneous();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
